instr_fetch_unit: RTL

Instruction-side memory responder for the pipeline's program counter. Each cycle it presents the instruction word for the current `pc` from a small prefetch queue, or signals that the instruction is not yet available. It prefetches sequential words over a single-outstanding req/ack memory port and redirects on any `pc` discontinuity (branch, data-dependency rewind). The top level gates the pipeline `clk_enable` with `instr_valid`.

---
 rtl/instr_fetch_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: presents the word at the pipeline's pc from a small
// prefetch queue and keeps that queue filled over a single-outstanding
// req/ack memory port. Any pc discontinuity flushes the queue and redirects
// fetching. A request already on the bus when a redirect arrives is drained,
// and its data is discarded.
module instr_fetch_unit #(
    parameter int          DEPTH      = 4,
    parameter logic [29:0] RESET_ADDR = 30'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] pc,
    input  logic        fetch_en,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = '0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [29:0]   fetch_addr;
    logic [29:0]   redirect_addr;

    // Queue storage carries no reset; occupancy (count) qualifies every read.
    logic [29:0]   q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];

    logic [29:0]   expected;
    logic          hit;
    logic          miss;
    logic          pop;
    logic          push;
    logic          ack_eff;

    // Hit/miss detection, queue pop/push decisions and next occupancy.
    always_comb begin
        expected = fetch_addr;
        if (count != '0) begin
            expected = q_addr[head];
        end else if (state == S_DRAIN) begin
            expected = redirect_addr;
        end
        hit     = (count != '0) && (q_addr[head] == pc);
        miss    = (pc != expected);
        pop     = fetch_en && hit;
        // An ack only completes a request that is actually on the bus.
        ack_eff = mem_ack && mem_req;
        push    = (state == S_REQ) && ack_eff && !miss;
        count_n = count;
        if (push && !pop) begin
            count_n = count + CNT_ONE;
        end else if (pop && !push) begin
            count_n = count - CNT_ONE;
        end
        instr_valid = hit;
        instr       = hit ? q_data[head] : 32'h0;
    end

    // Fetch control FSM, queue pointers and the registered memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            count         <= '0;
            head          <= PTR_ZERO;
            tail          <= PTR_ZERO;
            fetch_addr    <= RESET_ADDR;
            redirect_addr <= RESET_ADDR;
            mem_req       <= 1'b0;
            mem_addr      <= RESET_ADDR;
        end else begin
            if (pop) begin
                head <= head + PTR_ONE;
            end
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            count <= count_n;

            case (state)
                S_IDLE: begin
                    if (miss) begin
                        count      <= '0;
                        head       <= PTR_ZERO;
                        tail       <= PTR_ZERO;
                        fetch_addr <= pc;
                        mem_addr   <= pc;
                        mem_req    <= 1'b1;
                        state      <= S_REQ;
                    end else if (count_n < FULL) begin
                        mem_addr <= fetch_addr;
                        mem_req  <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack_eff && !miss) begin
                        fetch_addr <= fetch_addr + 30'd1;
                        if (count_n < FULL) begin
                            mem_addr <= fetch_addr + 30'd1;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end else if (ack_eff) begin
                        // Returned word belongs to the abandoned stream.
                        count      <= '0;
                        head       <= PTR_ZERO;
                        tail       <= PTR_ZERO;
                        fetch_addr <= pc;
                        mem_addr   <= pc;
                    end else if (miss) begin
                        // Bus must hold its address until ack; remember the target.
                        count         <= '0;
                        head          <= PTR_ZERO;
                        tail          <= PTR_ZERO;
                        redirect_addr <= pc;
                        state         <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (ack_eff) begin
                        fetch_addr <= miss ? pc : redirect_addr;
                        mem_addr   <= miss ? pc : redirect_addr;
                        state      <= S_REQ;
                    end else if (miss) begin
                        redirect_addr <= pc;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Prefetch queue write port.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= fetch_addr;
            q_data[tail] <= mem_rdata;
        end
    end

endmodule
